thresh_stream: RTL
==================

Name: thresh_stream

Overview:
- Streaming successor to the flat combinational pixel thresholder. Processes LANES pixels per beat over a valid/ready handshake, with four threshold modes.
- Threshold and mode are latched per frame.
- Produces a per-frame count of pixels at or above threshold, which feeds the defect-decision logic.
- Sits between the grayscale/filter stage and the defect classifier.

Parameters:
- DATA_WIDTH, 8: bits per pixel.
- LANES, 4: pixels per beat. Lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- CNT_WIDTH, 16: width of the frame defect counter. The counter saturates.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_threshold  in  DATA_WIDTH  live threshold T.
- cfg_mode  in  2  0=BINARY, 1=BINARY_INV, 2=TRUNC, 3=TOZERO.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  DATA_WIDTH*LANES  input pixels.
- in_last  in  1  last beat of frame.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_WIDTH*LANES  thresholded pixels.
- out_last  out  1  last beat of frame, passed through.
- cnt_valid  out  1  one-cycle pulse; cnt_value is valid.
- cnt_value  out  CNT_WIDTH  count of pixels >= T in the finished frame.
- busy  out  1  inside a frame (state IN_FRAME).

Behaviour:
- Reset: out_valid=0, out_data=0, out_last=0, cnt_valid=0, cnt_value=0, busy=0, state=IDLE, accumulator=0, shadow T=0, shadow mode=0. in_ready=1 after reset.
- Handshake:
  - A beat is accepted when in_valid&&in_ready.
  - in_ready = !out_valid || out_ready. This gives a single register stage at full throughput with no combinational path from in_valid to in_ready.
  - Output holds stable while out_valid&&!out_ready.
- Latency: an accepted beat appears on out_* on the next cycle.
- FSM IDLE:
  - Accepting a beat uses the live cfg_threshold/cfg_mode for that beat and latches them into the shadow registers.
  - If in_last=0, go to IN_FRAME.
  - If in_last=1, it is a one-beat frame: stay in IDLE.
- FSM IN_FRAME:
  - All beats use the shadow T/mode. cfg changes have no effect until the next frame.
  - Accepting an in_last beat returns to IDLE.
- Per-lane function, with p = pixel and MAX = all-ones:
  - BINARY: p>=T ? MAX : 0
  - BINARY_INV: p>=T ? 0 : MAX
  - TRUNC: p>=T ? T : p
  - TOZERO: p>=T ? p : 0
  - The comparison is unsigned. T=0 means every pixel passes.
- Counting:
  - beat_hits = number of lanes with p>=T, counted in every mode.
  - The accumulator adds beat_hits on each accepted beat and saturates at 2^CNT_WIDTH-1.
  - On accepting an in_last beat: cnt_value <= sat(acc+beat_hits), cnt_valid pulses for exactly 1 cycle (the cycle the last beat first appears on out_*), and acc <= 0.
  - cnt_valid does not wait for out_ready.
  - cnt_value holds until the next frame end.
- Boundaries:
  - Back-to-back frames with no gap are supported. The first beat of frame N+1 may be accepted the cycle after last of frame N, and uses the then-live cfg.
  - Downstream stall mid-frame: no beats are lost or duplicated, and the count is unaffected.
  - Reset mid-frame: returns to the reset state immediately. The partial frame is discarded and no cnt_valid is issued.

Optional Feature:
- Macro THRESH_MINMAX_EN.
- When defined:
  - Adds outputs frame_min and frame_max (each DATA_WIDTH). These are the minimum and maximum raw input pixel over all lanes of the frame.
  - They update together with cnt_valid and hold otherwise.
  - Reset values: frame_min=MAX, frame_max=0. The internal trackers re-initialise at each frame start.
- When undefined: the ports and logic are absent, and the rest of the behaviour is identical.

Test Plan:
- BINARY, T=0x80, one 1-beat frame in_data=lanes {0x7F,0x80,0xFF,0x00}, in_last=1 -> out lanes {0x00,0xFF,0xFF,0x00} one cycle later; cnt_valid pulse with cnt_value=2.
- Each mode with T=0x40 on lanes {0x3F,0x40,0x41,0x10} ->
  - BINARY_INV {0xFF,0,0,0xFF}
  - TRUNC {0x3F,0x40,0x40,0x10}
  - TOZERO {0,0x40,0x41,0}
- 3-beat frame, cfg_threshold changed 0x80->0x10 after beat 1 -> beats 2-3 still thresholded at 0x80; the next frame uses 0x10.
- Random out_ready (50% stall) over a 64-beat frame of all 0xFF -> all 64 beats out in order, out_last on beat 64 only, cnt_value=256.
- CNT_WIDTH=4, 5 beats all 0xFF -> cnt_value saturates at 15.
- Assert rst mid-frame after 2 beats, then send a 1-beat frame {0xFF x4} -> out_valid=0 during reset; the next cnt_value=4 with no earlier cnt_valid.

Source files
------------

// File: rtl/thresh_stream.sv
// Streaming LANES-wide pixel thresholder with per-frame latched cfg and a saturating hit counter.
// Optional frame min/max outputs are enabled by defining THRESH_MINMAX_EN.
module thresh_stream #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANES      = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       cfg_threshold,
  input  logic [1:0]                  cfg_mode,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH*LANES-1:0] in_data,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH*LANES-1:0] out_data,
  output logic                        out_last,
  output logic                        cnt_valid,
  output logic [CNT_WIDTH-1:0]        cnt_value,
`ifdef THRESH_MINMAX_EN
  output logic [DATA_WIDTH-1:0]       frame_min,
  output logic [DATA_WIDTH-1:0]       frame_max,
`endif
  output logic                        busy
);

  localparam int unsigned HitW = $clog2(LANES + 1);
  localparam int unsigned BusW = DATA_WIDTH * LANES;

  typedef enum logic [1:0] {
    ModeBinary    = 2'd0,
    ModeBinaryInv = 2'd1,
    ModeTrunc     = 2'd2,
    ModeToZero    = 2'd3
  } mode_e;

  typedef enum logic {StIdle, StInFrame} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] shadow_thr_q;
  mode_e                 shadow_mode_q;
  logic [CNT_WIDTH-1:0]  acc_q;

  logic                  accept;
  logic                  in_frame;
  logic [DATA_WIDTH-1:0] thr;
  mode_e                 mode;
  logic [DATA_WIDTH-1:0] lane_pix [LANES];
  logic [LANES-1:0]      lane_hit;
  logic [BusW-1:0]       thr_data;
  logic [HitW-1:0]       beat_hits;
  logic [CNT_WIDTH:0]    acc_sum;
  logic [CNT_WIDTH-1:0]  acc_next;

  function automatic logic [DATA_WIDTH-1:0] apply_thresh(input logic [DATA_WIDTH-1:0] p,
                                                         input logic [DATA_WIDTH-1:0] t,
                                                         input mode_e m);
    logic hit;
    logic [DATA_WIDTH-1:0] res;
    hit = (p >= t);
    case (m)
      ModeBinary:    res = hit ? '1 : '0;
      ModeBinaryInv: res = hit ? '0 : '1;
      ModeTrunc:     res = hit ? t : p;
      ModeToZero:    res = hit ? p : '0;
      default:       res = '0;
    endcase
    return res;
  endfunction

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign in_frame = (state_q == StInFrame);

  // The first beat of a frame sees the live cfg; later beats see the latched copy.
  assign thr  = in_frame ? shadow_thr_q : cfg_threshold;
  assign mode = in_frame ? shadow_mode_q : mode_e'(cfg_mode);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_pix[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign lane_hit[i] = (lane_pix[i] >= thr);
    assign thr_data[i*DATA_WIDTH +: DATA_WIDTH] = apply_thresh(lane_pix[i], thr, mode);
  end

  always_comb begin
    beat_hits = '0;
    for (int i = 0; i < LANES; i++) begin
      beat_hits = beat_hits + HitW'(lane_hit[i]);
    end
  end

  assign acc_sum  = {1'b0, acc_q} + (CNT_WIDTH + 1)'(beat_hits);
  assign acc_next = acc_sum[CNT_WIDTH] ? '1 : acc_sum[CNT_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      busy          <= 1'b0;
      shadow_thr_q  <= '0;
      shadow_mode_q <= ModeBinary;
    end else if (accept) begin
      if (!in_frame) begin
        shadow_thr_q  <= cfg_threshold;
        shadow_mode_q <= mode_e'(cfg_mode);
      end
      if (in_last) begin
        state_q <= StIdle;
        busy    <= 1'b0;
      end else begin
        state_q <= StInFrame;
        busy    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      cnt_valid <= 1'b0;
      cnt_value <= '0;
      acc_q     <= '0;
    end else begin
      cnt_valid <= accept && in_last;
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= thr_data;
        out_last  <= in_last;
        if (in_last) begin
          cnt_value <= acc_next;
          acc_q     <= '0;
        end else begin
          acc_q <= acc_next;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef THRESH_MINMAX_EN
  logic [DATA_WIDTH-1:0] beat_min, beat_max, cur_min, cur_max;
  logic [DATA_WIDTH-1:0] trk_min_q, trk_max_q;

  always_comb begin
    beat_min = '1;
    beat_max = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_pix[i] < beat_min) beat_min = lane_pix[i];
      if (lane_pix[i] > beat_max) beat_max = lane_pix[i];
    end
  end

  // Trackers restart from the first beat of each frame.
  assign cur_min = (in_frame && trk_min_q < beat_min) ? trk_min_q : beat_min;
  assign cur_max = (in_frame && trk_max_q > beat_max) ? trk_max_q : beat_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk_min_q <= '1;
      trk_max_q <= '0;
      frame_min <= '1;
      frame_max <= '0;
    end else if (accept) begin
      trk_min_q <= cur_min;
      trk_max_q <= cur_max;
      if (in_last) begin
        frame_min <= cur_min;
        frame_max <= cur_max;
      end
    end
  end
`endif

endmodule
